// File: rtl/uart_sched_pkg.sv
// Shared state encoding and default timing constants for the UART transmit scheduler.
package uart_sched_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_FREE,
    STROBE,
    WAIT_DONE,
    GAP
  } sched_state_t;

  localparam int BYTES_PER_WORD         = 4;
  localparam int DEFAULT_GAP_CYCLES     = 2;
  localparam int DEFAULT_TIMEOUT_CYCLES = 16384;

endpackage

// File: rtl/uart_tx_scheduler_rr_arbiter2.sv
// Two-requester round-robin arbiter: on a tie the requester that did not win last time is chosen.
module rr_arbiter2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  input  logic       accept,
  output logic [1:0] grant,
  output logic       winner
);

  always_comb begin
    winner = 1'b0;
    grant  = 2'b00;
    if (req == 2'b11) begin
      winner = ~last_grant;
    end else if (req[1]) begin
      winner = 1'b1;
    end
    if (accept && req[winner]) begin
      grant[winner] = 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares one uart_tx byte port between two requesters, sending a single byte or a 32-bit word LSB first.
// Define UART_TX_SCHED_WDT_EN to add a per-byte watchdog that abandons a stuck transfer and sets timeout_err.
module uart_tx_scheduler
  import uart_sched_pkg::*;
#(
  parameter int GAP_CYCLES = DEFAULT_GAP_CYCLES
`ifdef UART_TX_SCHED_WDT_EN
  ,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
`endif
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  input  logic [31:0] req0_data,
  input  logic        req0_word,
  output logic        req0_ready,
  output logic        req0_done,
  input  logic        req1_valid,
  input  logic [31:0] req1_data,
  input  logic        req1_word,
  output logic        req1_ready,
  output logic        req1_done,
  output logic        tx_send_en,
  output logic [7:0]  tx_data,
  input  logic        tx_active,
  input  logic        tx_done,
  output logic        busy,
  output logic        grant_id,
  output logic        timeout_err
);

  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  sched_state_t     state, state_n;
  logic [31:0]      shift_reg;
  logic [1:0]       bytes_left;
  logic [GAP_W-1:0] gap_cnt;
  logic             last_grant;
  logic [1:0]       grant;
  logic             winner;
  logic             accept;
  logic             done_pulse;
  logic             next_byte;
  logic             wdt_fire;

  rr_arbiter2 u_arb (
    .req        ({req1_valid, req0_valid}),
    .last_grant (last_grant),
    .accept     (state == IDLE),
    .grant      (grant),
    .winner     (winner)
  );

  assign accept     = |grant;
  assign req0_ready = grant[0];
  assign req1_ready = grant[1];
  assign req0_done  = done_pulse & ~grant_id;
  assign req1_done  = done_pulse & grant_id;
  assign tx_data    = shift_reg[7:0];
  assign busy       = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n    = state;
    tx_send_en = 1'b0;
    done_pulse = 1'b0;
    next_byte  = 1'b0;
    case (state)
      IDLE:      if (accept) state_n = WAIT_FREE;
      WAIT_FREE: if (!tx_active) state_n = STROBE;
      STROBE: begin
        tx_send_en = 1'b1;
        state_n    = WAIT_DONE;
      end
      WAIT_DONE: if (tx_done) state_n = GAP;
      GAP: begin
        if (gap_cnt == '0) begin
          if (bytes_left == 2'd0) begin
            done_pulse = 1'b1;
            state_n    = IDLE;
          end else begin
            next_byte = 1'b1;
            state_n   = WAIT_FREE;
          end
        end
      end
      default:   state_n = IDLE;
    endcase
    // The watchdog overrides whatever the byte sequencing wanted this cycle.
    if (wdt_fire) begin
      done_pulse = 1'b1;
      state_n    = IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_reg  <= '0;
      bytes_left <= 2'd0;
      gap_cnt    <= '0;
      grant_id   <= 1'b0;
      last_grant <= 1'b1;
    end else begin
      if (state == IDLE && accept) begin
        shift_reg  <= winner ? req1_data : req0_data;
        bytes_left <= (winner ? req1_word : req0_word) ? 2'(BYTES_PER_WORD - 1) : 2'd0;
        grant_id   <= winner;
        last_grant <= winner;
      end else if (next_byte) begin
        shift_reg  <= {8'h00, shift_reg[31:8]};
        bytes_left <= bytes_left - 2'd1;
      end
      if (state == WAIT_DONE && tx_done) begin
        gap_cnt <= GAP_W'(GAP_CYCLES - 1);
      end else if (state == GAP && gap_cnt != '0) begin
        gap_cnt <= gap_cnt - 1'b1;
      end
    end
  end

`ifdef UART_TX_SCHED_WDT_EN
  localparam int WDT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [WDT_W-1:0] wdt_cnt;
  logic             timeout_q;

  // Counts cycles spent waiting on uart_tx; restarts whenever the state changes.
  assign wdt_fire    = ((state == WAIT_FREE) || (state == WAIT_DONE)) &&
                       (wdt_cnt == WDT_W'(TIMEOUT_CYCLES - 1));
  assign timeout_err = timeout_q | wdt_fire;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdt_cnt   <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (state_n != state) begin
        wdt_cnt <= '0;
      end else if (state == WAIT_FREE || state == WAIT_DONE) begin
        wdt_cnt <= wdt_cnt + 1'b1;
      end
      if (wdt_fire) begin
        timeout_q <= 1'b1;
      end
    end
  end
`else
  assign wdt_fire    = 1'b0;
  assign timeout_err = 1'b0;
`endif

endmodule

// File: doc/uart_tx_scheduler.md
Name: uart_tx_scheduler

Overview:
- Shares the single byte-wide UART transmitter between two requesters: port 0 is the CPU MMIO mapper, port 1 is the debug/monitor source.
- Serialises a 32-bit word into 4 bytes, LSB first, or sends a single byte.
- Issues one send strobe per byte and waits for the transmitter's done pulse before the next byte.
- Sits between the MMIO mapper / debug source and the uart_tx byte interface inside the UART controller.

Parameters:
- GAP_CYCLES, 2, idle cycles after each tx_done before the next send strobe (min 1).
- TIMEOUT_CYCLES, 16384, watchdog limit per byte in cycles (one byte at 115200 baud / 100 MHz is about 8680 cycles); used only with the optional feature.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- req0_valid  in  1  requester 0 has a transfer
- req0_data  in  32  requester 0 payload; byte mode uses [7:0]
- req0_word  in  1  1 = send 4 bytes, 0 = send 1 byte
- req0_ready  out  1  requester 0 transfer accepted this cycle
- req0_done  out  1  one-cycle pulse when requester 0 transfer completes
- req1_valid / req1_data / req1_word / req1_ready / req1_done  same as above, for requester 1
- tx_send_en  out  1  one-cycle strobe to uart_tx
- tx_data  out  8  byte to uart_tx, held stable from strobe until done
- tx_active  in  1  uart_tx busy
- tx_done  in  1  uart_tx one-cycle completion pulse
- busy  out  1  high in any state except IDLE
- grant_id  out  1  requester currently being served; holds last value when idle
- timeout_err  out  1  sticky watchdog error (feature only; tied 0 otherwise)

Behaviour:
- Reset values: all outputs 0; state IDLE; last_grant = 1, so requester 0 wins the first tie.
- Acceptance: readyN is combinationally high in IDLE for the arbitration winner only, when its validN is high. Acceptance happens when readyN && validN.
- On acceptance: latch data into shift_reg, set bytes_left = word ? 3 : 0, set grant_id = winner, update last_grant.
- Arbitration: round-robin. If both valid, grant the requester that is not last_grant; if one is valid, grant it.
- States:
  - IDLE -> WAIT_FREE on acceptance.
  - WAIT_FREE: wait until tx_active == 0, then -> STROBE.
  - STROBE: tx_send_en = 1 for exactly one cycle, tx_data = shift_reg[7:0], -> WAIT_DONE.
  - WAIT_DONE: on tx_done, -> GAP and load the gap counter with GAP_CYCLES-1.
  - GAP: counts down to 0. Then, if bytes_left == 0, pulse reqN_done for the granted requester and -> IDLE. Otherwise shift_reg >>= 8, bytes_left -= 1, -> WAIT_FREE.
- Latency: acceptance to first tx_send_en is 2 cycles when tx_active is low. A done pulse lands GAP_CYCLES cycles after the last tx_done.
- A tx_done outside WAIT_DONE is ignored.
- Requests are never preempted; a word always completes all 4 bytes.
- validN falling mid-transfer has no effect on the transfer.
- A new request cannot be accepted in the same cycle a done pulse is issued; the earliest acceptance is the next cycle in IDLE.
- Reset asserted mid-transfer: immediate return to reset values and no done pulse. uart_tx may still finish its byte; the resulting tx_done is ignored in IDLE.
- bytes_left is 2 bits and never wraps: the decrement happens only when bytes_left > 0.

Optional Feature:
- Macro: UART_TX_SCHED_WDT_EN.
- With the macro: a cycle counter runs in WAIT_FREE and WAIT_DONE and clears on every state change. On reaching TIMEOUT_CYCLES, the block abandons the transfer, sets timeout_err (sticky until reset), pulses the granted reqN_done, and returns to IDLE.
- Without the macro: no counter logic, timeout_err tied to 0, and the block waits indefinitely.

Decomposition:
- Package uart_sched_pkg:
  - state enum (IDLE, WAIT_FREE, STROBE, WAIT_DONE, GAP)
  - BYTES_PER_WORD = 4
  - default GAP_CYCLES and TIMEOUT_CYCLES constants
- Sub-module rr_arbiter2: 2-requester round-robin arbiter with inputs req[1:0], last_grant and accept, and outputs grant one-hot and winner id. All other logic stays in one FSM module.

Test Plan:
- Byte send: req0 valid with data 0x000000A5, word = 0. Expect a single tx_send_en with tx_data 0xA5. A tx_done stubbed 8680 cycles later gives req0_done 2 cycles after it; busy then returns to 0.
- Word send: req1 with data 0x11223344, word = 1. Expect four strobes with tx_data 0x44, 0x33, 0x22, 0x11 in order, each strobe at least 2 cycles after the previous tx_done, and exactly one req1_done.
- Tie arbitration: both requesters valid in the first cycle after reset. Expect grant 0 first, then grant 1. Both still valid after that gives grant 0 again (alternation).
- tx_active held high for 50 cycles at acceptance: the strobe must not occur until tx_active falls, and occurs 1 cycle later. A spurious tx_done injected in IDLE causes no state change.
- Reset mid-word (after the 2nd byte's strobe): all outputs are 0 immediately and no done pulse occurs. A following byte request works normally.
- With UART_TX_SCHED_WDT_EN and TIMEOUT_CYCLES = 100, with tx_done withheld: timeout_err rises 100 cycles after the strobe, req0_done pulses, state returns to IDLE, and timeout_err stays high until rst_n.
